apb_slave_regbank: RTL and testbench

// APB responder (completer) for the team's 4-select APB fabric: decodes one psel bit, runs

---
 rtl/apb_slave_regbank_pkg.sv | 28 ++
 rtl/apb_slave_regbank_if.sv | 21 ++
 rtl/apb_slave_regbank_regfile.sv | 35 +++
 rtl/apb_slave_regbank.sv | 140 ++++++++++++++
 tb/tb_apb_slave_regbank.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and the address decode rule for the APB register-bank responder.
package apb_slave_regbank_pkg;

  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } presp_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Out of range wins over misalignment.
  function automatic presp_e decode_resp(input logic [APB_DW-1:0] addr,
                                         input logic [APB_DW-1:0] base,
                                         input int                nregs);
    logic [APB_DW-1:0] span;
    span = APB_DW'(nregs) << 2;
    if (addr < base || (addr - base) >= span) return DECERR;
    if (addr[1:0] != 2'b00) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle shared by the fabric master and the register-bank responder.
interface apb_slave_regbank_if;
  import apb_slave_regbank_pkg::*;

  // Handshake: a transfer is a setup cycle (psel high, penable low) followed by access
  // cycles (psel and penable high); it completes on the rising edge where
  // psel & penable & pready are all high, and presp/prdata are valid only in that cycle.
  logic [3:0]        psel;
  logic [APB_DW-1:0] paddr;
  logic [APB_DW-1:0] pwdata;
  logic              pwrite;
  logic              penable;
  logic [APB_DW-1:0] prdata;
  logic              pready;
  logic [1:0]        presp;

  modport master (output psel, paddr, pwdata, pwrite, penable,
                  input  prdata, pready, presp);
  modport slave  (input  psel, paddr, pwdata, pwrite, penable,
                  output prdata, pready, presp);
endinterface

// File: rtl/apb_slave_regbank_regfile.sv
// Word register array: reg0 is a fixed read-only ID, the rest are plain read/write.
module apb_slave_regbank_regfile
  import apb_slave_regbank_pkg::*;
#(
  parameter int                NUM_REGS = 16,
  parameter logic [APB_DW-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(NUM_REGS)-1:0]  widx,
  input  logic [APB_DW-1:0]            wdata,
  input  logic [$clog2(NUM_REGS)-1:0]  ridx,
  output logic [APB_DW-1:0]            rdata,
  output logic [NUM_REGS*APB_DW-1:0]   regs_o
);

  logic [APB_DW-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= (i == 0) ? ID_VALUE : '0;
    end else if (we && widx != '0) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*APB_DW +: APB_DW] = mem[i];
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer on one psel bit: setup/access handshake with fixed wait states,
// registered response, serving a word-addressed register bank.
module apb_slave_regbank
  import apb_slave_regbank_pkg::*;
#(
  parameter int                SEL_IDX     = 0,
  parameter logic [APB_DW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                NUM_REGS    = 16,
  parameter int                WAIT_STATES = 0,
  parameter logic [APB_DW-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                       pclk,
  input  logic                       prst,
  apb_slave_regbank_if.slave         bus,
  output logic [NUM_REGS*APB_DW-1:0] regs_o,
  output state_e                     dbg_state
);

  localparam int          IW = $clog2(NUM_REGS);
  localparam int          CW = 4;
  localparam logic [1:0]  SI = 2'(SEL_IDX);

  state_e            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [APB_DW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic              pready_q, pready_d;
  presp_e            presp_q, presp_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic              we;

  logic              sel;
  logic [APB_DW-1:0] cur_addr;
  logic              cur_write;
  presp_e            cur_resp;
  logic [IW-1:0]     cur_idx;
  logic [APB_DW-1:0] rdata;
  logic [APB_DW-1:0] resp_data;

  assign sel = bus.psel[SI];

  // In IDLE the response is built from the live bus so zero-wait transfers can
  // raise pready on the setup edge; in ACCESS it comes from the latched transfer.
  assign cur_addr  = (state == IDLE) ? bus.paddr  : addr_q;
  assign cur_write = (state == IDLE) ? bus.pwrite : write_q;
  assign cur_resp  = decode_resp(cur_addr, BASE_ADDR, NUM_REGS);
  assign cur_idx   = IW'((cur_addr - BASE_ADDR) >> 2);
  assign resp_data = (cur_resp == OKAY && !cur_write) ? rdata : '0;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      pready_q <= 1'b0;
      presp_q  <= OKAY;
      prdata_q <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      pready_q <= pready_d;
      presp_q  <= presp_d;
      prdata_q <= prdata_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    pready_d = 1'b0;
    presp_d  = OKAY;
    prdata_d = '0;
    we       = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !bus.penable) begin
          state_d = ACCESS;
          addr_d  = bus.paddr;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          cnt_d   = CW'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            pready_d = 1'b1;
            presp_d  = cur_resp;
            prdata_d = resp_data;
          end
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (pready_q && bus.penable) begin
          state_d = IDLE;
          we      = write_q && (presp_q == OKAY);
        end else if (pready_q) begin
          pready_d = 1'b1;
          presp_d  = presp_q;
          prdata_d = prdata_q;
        end else if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            pready_d = 1'b1;
            presp_d  = cur_resp;
            prdata_d = resp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  apb_slave_regbank_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk    (pclk),
    .rst_n  (prst),
    .we     (we),
    .widx   (cur_idx),
    .wdata  (wdata_q),
    .ridx   (cur_idx),
    .rdata  (rdata),
    .regs_o (regs_o)
  );

  assign bus.pready = pready_q;
  assign bus.presp  = presp_q;
  assign bus.prdata = prdata_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Three responders (wait states 0/3/2) on one shared APB bus, checked against a register-array model.
module tb_apb_slave_regbank;
  import apb_slave_regbank_pkg::*;

  localparam int          W    = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          WAITS [3] = '{0, 3, 2};

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic prst;

  logic [3:0]  psel;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable;

  apb_slave_regbank_if bus0 ();
  apb_slave_regbank_if bus1 ();
  apb_slave_regbank_if bus2 ();

  assign bus0.psel = psel;  assign bus0.paddr = paddr;  assign bus0.pwdata = pwdata;
  assign bus0.pwrite = pwrite;  assign bus0.penable = penable;
  assign bus1.psel = psel;  assign bus1.paddr = paddr;  assign bus1.pwdata = pwdata;
  assign bus1.pwrite = pwrite;  assign bus1.penable = penable;
  assign bus2.psel = psel;  assign bus2.paddr = paddr;  assign bus2.pwdata = pwdata;
  assign bus2.pwrite = pwrite;  assign bus2.penable = penable;

  logic            pready_a [3];
  logic [1:0]      presp_a  [3];
  logic [W-1:0]    prdata_a [3];
  logic [NR*W-1:0] regs_a   [3];
  state_e          st_a     [3];

  assign pready_a[0] = bus0.pready;  assign presp_a[0] = bus0.presp;  assign prdata_a[0] = bus0.prdata;
  assign pready_a[1] = bus1.pready;  assign presp_a[1] = bus1.presp;  assign prdata_a[1] = bus1.prdata;
  assign pready_a[2] = bus2.pready;  assign presp_a[2] = bus2.presp;  assign prdata_a[2] = bus2.prdata;

  apb_slave_regbank #(.SEL_IDX(0), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(0),
                      .ID_VALUE(32'hA9B0_0001)) dut0 (
    .pclk(pclk), .prst(prst), .bus(bus0.slave), .regs_o(regs_a[0]), .dbg_state(st_a[0]));
  apb_slave_regbank #(.SEL_IDX(1), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(3),
                      .ID_VALUE(32'hA9B0_0002)) dut1 (
    .pclk(pclk), .prst(prst), .bus(bus1.slave), .regs_o(regs_a[1]), .dbg_state(st_a[1]));
  apb_slave_regbank #(.SEL_IDX(2), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(2),
                      .ID_VALUE(32'hA9B0_0003)) dut2 (
    .pclk(pclk), .prst(prst), .bus(bus2.slave), .regs_o(regs_a[2]), .dbg_state(st_a[2]));

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] model [3][NR];

  task automatic check_eq(input string tag, input logic [NR*W-1:0] got, input logic [NR*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] id_of(input int t);
    return 32'hA9B0_0001 + 32'(t);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < NR; k++) model[t][k] = (k == 0) ? id_of(t) : '0;
  endtask

  function automatic logic [NR*W-1:0] model_flat(input int t);
    logic [NR*W-1:0] f;
    f = '0;
    for (int k = 0; k < NR; k++) f[k*W +: W] = model[t][k];
    return f;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    if (a < BASE || a >= BASE + 4 * NR) return 2'b11;
    if (a % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_regs_all(input string tag);
    for (int k = 0; k < 3; k++) check_eq(tag, regs_a[k], model_flat(k));
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left #1 after a rising edge, so transfers can be issued back-to-back.
  task automatic apb_xfer(input int t, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, output logic [1:0] resp,
                          output logic [31:0] rd, output int waits);
    bit done;
    bit to;
    psel = 4'(1 << t); paddr = addr; pwrite = wr; pwdata = wd; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0; done = 0; to = 0; resp = '0; rd = '0;
    while (!done) begin
      @(negedge pclk);
      if (pready_a[t]) begin
        resp = presp_a[t];
        rd   = prdata_a[t];
        done = 1;
      end else begin
        check_eq("quiet_presp", presp_a[t], 2'b00);
        check_eq("quiet_prdata", prdata_a[t], '0);
        waits++;
        if (waits > 40) begin to = 1; done = 1; end
      end
    end
    check_eq("pready_timeout", to, 1'b0);
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
  endtask

  task automatic do_xfer(input int t, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, output logic [1:0] resp, output logic [31:0] rd);
    logic [1:0]   er;
    logic [W-1:0] exp;
    int           idx;
    int           waits;
    er  = model_resp(addr);
    idx = int'((addr - BASE) >> 2);
    exp_q.push_back((!wr && er == 2'b00) ? model[t][idx] : '0);
    apb_xfer(t, addr, wr, wd, resp, rd, waits);
    exp = exp_q.pop_front();
    check_eq("waits", waits, WAITS[t]);
    check_eq("presp", resp, er);
    if (!wr) check_eq("prdata", rd, exp);
    if (wr && er == 2'b00 && idx != 0) model[t][idx] = wd;
    check_regs_all("regs_after_xfer");
  endtask

  task automatic idle(input int n);
    psel = '0; penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq({tag, "_pready"}, pready_a[k], 1'b0);
      check_eq({tag, "_presp"}, presp_a[k], 2'b00);
      check_eq({tag, "_prdata"}, prdata_a[k], '0);
      check_eq({tag, "_state"}, st_a[k], IDLE);
    end
    check_regs_all({tag, "_regs"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] a;
    prst = 1'b0; psel = '0; paddr = '0; pwdata = '0; pwrite = 1'b0; penable = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check_reset_outputs("reset");
    prst = 1'b1;
    @(posedge pclk); #1;

    // zero-wait write/read
    do_xfer(0, BASE + 4, 1'b1, 32'hDEADBEEF, r, d);
    do_xfer(0, BASE + 4, 1'b0, '0, r, d);
    check_eq("w0_rd_deadbeef", d, 32'hDEADBEEF);

    // three wait states, ID register, read-only reg0
    do_xfer(1, BASE + 0, 1'b0, '0, r, d);
    check_eq("w3_rd_id", d, 32'hA9B0_0002);
    do_xfer(1, BASE + 0, 1'b1, 32'h0000_1234, r, d);
    check_eq("ro_wr_okay", r, 2'b00);
    do_xfer(1, BASE + 0, 1'b0, '0, r, d);
    check_eq("ro_rd_id", d, 32'hA9B0_0002);

    // error decode
    do_xfer(0, BASE + 32'h40, 1'b0, '0, r, d);
    check_eq("decerr_resp", r, 2'b11);
    check_eq("decerr_data", d, '0);
    do_xfer(0, BASE + 6, 1'b1, 32'hCAFE_0006, r, d);
    check_eq("slverr_resp", r, 2'b10);
    do_xfer(0, BASE - 4, 1'b0, '0, r, d);
    check_eq("below_base_resp", r, 2'b11);

    // back-to-back with no idle cycles
    do_xfer(2, BASE + 8, 1'b1, 32'h1111_2222, r, d);
    do_xfer(2, BASE + 12, 1'b1, 32'h3333_4444, r, d);
    do_xfer(2, BASE + 8, 1'b0, '0, r, d);
    check_eq("b2b_rd8", d, 32'h1111_2222);
    do_xfer(2, BASE + 12, 1'b0, '0, r, d);
    check_eq("b2b_rdc", d, 32'h3333_4444);
    do_xfer(0, BASE + 8, 1'b1, 32'h5555_6666, r, d);
    do_xfer(0, BASE + 8, 1'b0, '0, r, d);

    // penable without setup is ignored
    psel = 4'b0001; penable = 1'b1; pwrite = 1'b1; paddr = BASE + 16; pwdata = 32'hBAD0_BAD0;
    repeat (3) begin
      @(negedge pclk);
      check_eq("noset_pready", pready_a[0], 1'b0);
      check_eq("noset_state", st_a[0], IDLE);
    end
    @(posedge pclk); #1;
    idle(1);
    check_regs_all("noset_regs");

    // psel dropped mid-access
    psel = 4'b0010; paddr = BASE + 16; pwrite = 1'b1; pwdata = 32'h55AA_55AA; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check_eq("abort_pready_pre", pready_a[1], 1'b0);
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    check_eq("abort_state", st_a[1], IDLE);
    repeat (4) begin
      @(negedge pclk);
      check_eq("abort_pready", pready_a[1], 1'b0);
    end
    @(posedge pclk); #1;
    check_regs_all("abort_regs");
    do_xfer(1, BASE + 16, 1'b0, '0, r, d);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      int t;
      t = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'h40 + 32'(4 * $urandom_range(0, 15));
        1:       a = BASE - 32'(4 * $urandom_range(1, 4));
        2:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      do_xfer(t, a, 1'($urandom_range(0, 1)), $urandom, r, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end

    // reset in the middle of a write on the two-wait responder
    psel = 4'b0100; paddr = BASE + 20; pwrite = 1'b1; pwdata = 32'h7777_8888; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    prst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    check_reset_outputs("post_rst");
    do_xfer(2, BASE + 20, 1'b0, '0, r, d);
    check_eq("midrst_no_write", d, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
